// File: rtl/cnn_csr_bank.sv
// cnn_csr_bank: CH-channel CSR bank (setting, start/busy/done handshake, W1C status, IRQ).
// Define CNN_CSR_IRQ_EN to build the IRQ_EN register and irq_o logic; otherwise irq_o is 0.
module cnn_csr_bank #(
  parameter int CH = 4,
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data,
  output logic [CH-1:0]    start_o,
  output logic [CH-1:0]    busy_o,
  output logic [CH*DW-1:0] setting_o,
  input  logic [CH-1:0]    engine_done_i,
  output logic             irq_o
);
  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_STATUS = AW'(1);
  localparam logic [AW-1:0] A_IRQ_EN = AW'(2);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY} ch_state_t;

  ch_state_t     r_state     [CH];
  ch_state_t     w_state_nxt [CH];
  logic [DW-1:0] r_setting   [CH];
  logic [CH-1:0] r_done, r_err, w_irq_en;
  logic [CH-1:0] w_req, w_done_set, w_err_set, w_done_clr, w_err_clr;
  logic          w_ctrl_wr, w_stat_wr;
  logic [DW-1:0] w_rd_mux;

  assign w_ctrl_wr  = wr_en && (wr_addr == A_CTRL);
  assign w_stat_wr  = wr_en && (wr_addr == A_STATUS);
  assign w_req      = w_ctrl_wr ? wr_data[CH-1:0] : '0;
  assign w_done_clr = w_stat_wr ? wr_data[CH-1:0] : '0;
  assign w_err_clr  = w_stat_wr ? wr_data[2*CH +: CH] : '0;

  always_comb begin
    start_o    = '0;
    busy_o     = '0;
    w_done_set = '0;
    w_err_set  = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE: begin
          if (w_req[i]) w_state_nxt[i] = ST_START;
        end
        ST_START: begin
          start_o[i]     = 1'b1;
          busy_o[i]      = 1'b1;
          w_err_set[i]   = w_req[i];
          w_state_nxt[i] = ST_BUSY;
        end
        ST_BUSY: begin
          busy_o[i]    = 1'b1;
          w_err_set[i] = w_req[i];
          if (engine_done_i[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_done_set[i]  = 1'b1;
          end
        end
        default: w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    setting_o = '0;
    for (int unsigned i = 0; i < CH; i++) setting_o[i*DW +: DW] = r_setting[i];
  end

  // Read mux sees pre-edge state, so a same-cycle write is not visible to the read.
  always_comb begin
    w_rd_mux = '0;
    if (rd_addr == A_STATUS) begin
      w_rd_mux[0 +: CH]    = r_done;
      w_rd_mux[CH +: CH]   = busy_o;
      w_rd_mux[2*CH +: CH] = r_err;
    end else if (rd_addr == A_IRQ_EN) begin
      w_rd_mux[0 +: CH] = w_irq_en;
    end
    for (int unsigned i = 0; i < CH; i++) begin
      if (rd_addr == AW'(4 + i)) w_rd_mux = r_setting[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_state[i]   <= ST_IDLE;
        r_setting[i] <= '0;
      end
      r_done  <= '0;
      r_err   <= '0;
      rd_data <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (wr_en && (wr_addr == AW'(4 + i)) && (r_state[i] == ST_IDLE))
          r_setting[i] <= wr_data;
      end
      r_done <= (r_done & ~w_done_clr) | w_done_set;
      r_err  <= (r_err & ~w_err_clr) | w_err_set;
      if (rd_en) rd_data <= w_rd_mux;
    end
  end

`ifdef CNN_CSR_IRQ_EN
  logic [CH-1:0] r_irq_en;
  logic          r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == A_IRQ_EN)) r_irq_en <= wr_data[CH-1:0];
      r_irq <= |(r_done & r_irq_en);
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq_o    = r_irq;
`else
  assign w_irq_en = '0;
  assign irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_csr_bank.sv
// Self-checking bench for cnn_csr_bank: per-cycle model comparison plus directed literal checks.
module tb_cnn_csr_bank;
  localparam int CH = 4;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef CNN_CSR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             rd_en = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [DW-1:0]    rd_data;
  logic [CH-1:0]    start_o;
  logic [CH-1:0]    busy_o;
  logic [CH*DW-1:0] setting_o;
  logic [CH-1:0]    engine_done_i = '0;
  logic             irq_o;

  always #5 clk = ~clk;

  cnn_csr_bank #(.CH(CH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .start_o(start_o), .busy_o(busy_o), .setting_o(setting_o),
    .engine_done_i(engine_done_i), .irq_o(irq_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [CH*DW-1:0] act,
                       input logic [CH*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age counts cycles since a channel was started (0 = idle, 1 = start pulse cycle).
  int            m_age [CH];
  logic [DW-1:0] m_set [CH];
  logic [CH-1:0] m_done, m_err, m_ien;
  logic [DW-1:0] m_rd;
  logic          m_irq;

  function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    int ai;
    v  = '0;
    ai = int'(a);
    if (ai == 1) begin
      for (int i = 0; i < CH; i++) begin
        v[i]        = m_done[i];
        v[CH + i]   = (m_age[i] > 0);
        v[2*CH + i] = m_err[i];
      end
    end else if (ai == 2) begin
      v[CH-1:0] = m_ien;
    end else if (ai >= 4 && ai < 4 + CH) begin
      v = m_set[ai - 4];
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [CH-1:0] nd, ne;
    bit            was_active;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_age[i] = 0;
        m_set[i] = '0;
      end
      m_done = '0; m_err = '0; m_ien = '0; m_rd = '0; m_irq = 1'b0;
    end else begin
      nd = m_done;
      ne = m_err;
      if (rd_en) m_rd = mdl_read(rd_addr);
      m_irq = IRQ_ON && |(m_done & m_ien);
      if (wr_en && int'(wr_addr) == 1) begin
        nd = nd & ~wr_data[CH-1:0];
        ne = ne & ~wr_data[2*CH +: CH];
      end
      for (int i = 0; i < CH; i++) begin
        was_active = (m_age[i] > 0);
        if (wr_en && int'(wr_addr) == 4 + i && !was_active) m_set[i] = wr_data;
        if (m_age[i] >= 2 && engine_done_i[i]) begin
          m_age[i] = 0;
          nd[i]    = 1'b1;
        end else if (was_active) begin
          m_age[i] = m_age[i] + 1;
        end
        if (wr_en && int'(wr_addr) == 0 && wr_data[i]) begin
          if (was_active) ne[i] = 1'b1;
          else m_age[i] = 1;
        end
      end
      if (IRQ_ON && wr_en && int'(wr_addr) == 2) m_ien = wr_data[CH-1:0];
      m_done = nd;
      m_err  = ne;
    end
  end

  always @(negedge clk) begin
    logic [CH*DW-1:0] exp_set;
    logic [CH-1:0]    es, eb;
    for (int i = 0; i < CH; i++) begin
      es[i] = (m_age[i] == 1);
      eb[i] = (m_age[i] > 0);
      exp_set[i*DW +: DW] = m_set[i];
    end
    check("cyc_start_o", start_o, es);
    check("cyc_busy_o", busy_o, eb);
    check("cyc_setting_o", setting_o, exp_set);
    check("cyc_irq_o", irq_o, m_irq);
    check("cyc_rd_data", rd_data, m_rd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_start_o", start_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_irq_o", irq_o, 0);
    for (int a = 0; a < 4 + CH; a++) begin
      rd(AW'(a));
      check("rst_rd", rd_data, 0);
    end

    wr(4'd6, 32'hA5A5_0003);
    rd(4'd6);
    check("set2_rd", rd_data, 32'hA5A5_0003);
    check("set2_out", setting_o[95:64], 32'hA5A5_0003);
    check("mdl_set2", m_rd, 32'hA5A5_0003);

    wr(4'd0, 32'h5);
    check("start_pulse", start_o, 4'h5);
    check("start_busy", busy_o, 4'h5);
    tick();
    check("start_end", start_o, 4'h0);
    check("busy_hold", busy_o, 4'h5);
    engine_done_i = 4'h1;
    tick();
    engine_done_i = 4'h0;
    check("done_busy", busy_o, 4'h4);
    rd(4'd1);
    check("status_041", rd_data, 32'h041);
    check("mdl_status_041", m_rd, 32'h041);

    wr(4'd0, 32'h4);
    check("restart_no_pulse", start_o, 4'h0);
    rd(4'd1);
    check("status_err", rd_data, 32'h441);
    wr(4'd6, 32'h0);
    rd(4'd6);
    check("set2_locked", rd_data, 32'hA5A5_0003);

    wr(4'd2, 32'h1);
    tick();
    check("irq_rise", irq_o, IRQ_ON);
    rd(4'd2);
    check("irq_en_rd", rd_data, IRQ_ON ? 32'h1 : 32'h0);
    wr(4'd0, 32'h1);
    tick();
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h1; engine_done_i = 4'h1;
    tick();
    wr_en = 1'b0; engine_done_i = 4'h0;
    rd(4'd1);
    check("set_wins", rd_data, 32'h441);
    check("irq_held", irq_o, IRQ_ON);
    wr(4'd1, 32'h1);
    check("irq_lag", irq_o, IRQ_ON);
    tick();
    check("irq_fall", irq_o, 1'b0);
    rd(4'd1);
    check("status_w1c", rd_data, 32'h440);

    wr_en = 1'b1; rd_en = 1'b1; wr_addr = 4'd5; rd_addr = 4'd5; wr_data = 32'h1234;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw_same_old", rd_data, 32'h0);
    rd(4'd5);
    check("rw_same_new", rd_data, 32'h1234);

    wr(4'd3, '1);
    wr(4'd9, '1);
    rd(4'd3);
    check("unmapped3", rd_data, 32'h0);
    rd(4'd9);
    check("unmapped9", rd_data, 32'h0);
    wr(4'd1, 32'h0F0);
    rd(4'd1);
    check("busy_ro", rd_data, 32'h440);
    wr(4'd1, 32'h400);
    rd(4'd1);
    check("err_w1c", rd_data, 32'h040);
    engine_done_i = 4'h4;
    tick();
    engine_done_i = 4'h1;
    tick();
    engine_done_i = 4'h0;
    rd(4'd1);
    check("done2_idle_done0", rd_data, 32'h004);

    wr(4'd0, 32'h2);
    tick();
    #2 rst = 1'b1;
    #1;
    check("async_busy", busy_o, 4'h0);
    check("async_start", start_o, 4'h0);
    check("async_irq", irq_o, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    engine_done_i = 4'h2;
    tick();
    engine_done_i = 4'h0;
    rd(4'd1);
    check("late_done_ignored", rd_data, 32'h0);
    rd(4'd5);
    check("set1_reset", rd_data, 32'h0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cnn_csr_bank.md
# cnn_csr_bank

Parametrised control/status register bank for the CNN accelerator; it generalises the single 2-bit setting-done register into CH independent layer channels. Each channel has a DW-bit setting register, a start/busy/done handshake with its compute engine, sticky done/error flags with write-one-to-clear, and a maskable interrupt. It sits between the CPU-side register bus and the per-layer CNN engines.

## Interface
- CH, 4, number of layer channels (1..8); requires DW >= 3*CH
- DW, 32, bus data width
- AW, 4, register address width; requires 2^AW >= 4+CH
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write strobe, one write per asserted cycle
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- rd_en  in  1  read strobe
- rd_addr  in  AW  read address
- rd_data  out  DW  registered read data
- start_o  out  CH  per-channel one-cycle start pulse to engine
- busy_o  out  CH  per-channel busy level
- setting_o  out  CH*DW  per-channel setting register contents, channel i at [i*DW +: DW]
- engine_done_i  in  CH  per-channel completion pulse from engine
- irq_o  out  1  registered interrupt

## Operation
- Register map (word addresses):
  - 0 CTRL, write-only: a 1 in bit i requests start of channel i; reads 0.
  - 1 STATUS: [CH-1:0] done, sticky, W1C; [2CH-1:CH] busy, read-only; [3CH-1:2CH] err, sticky, W1C; upper bits read 0.
  - 2 IRQ_EN: [CH-1:0] done-interrupt enable, R/W; upper bits read 0.
  - 4+i SETTING[i]: DW-bit R/W. Writes are ignored while channel i is busy.
- Unmapped addresses read 0; writes to them and to read-only fields are ignored.
- Per-channel FSM:
  - IDLE -> START on a CTRL write with bit i = 1.
  - START -> BUSY unconditionally after one cycle; start_o[i] = 1 only in START.
  - BUSY -> IDLE on engine_done_i[i]; this sets done[i].
  - busy_o[i] = 1 in START and BUSY.
- A start request while in START or BUSY is ignored and sets err[i].
- engine_done_i[i] outside BUSY is ignored.
- Simultaneous W1C clear and set of the same done/err bit: the set wins.
- irq_o = OR over i of (done[i] & irq_en[i]), registered.

## Timing
- Reset values: all FSMs IDLE; start_o, busy_o, done, err, irq_en, every SETTING, rd_data, irq_o all 0.
- CTRL write sampled at edge T: start_o[i] and busy_o[i] high after T; start_o low after T+1.
- engine_done_i sampled at edge D: busy_o low and done set after D; irq_o high after D+1.
- A W1C write at edge C clears bits after C; irq_o falls after C+1.
- Reads: rd_en sampled at edge R; rd_data valid after R and held until the next rd_en.
- A read and write to the same address in the same cycle return the pre-write value.
- Reset asserted mid-operation forces all state to reset values immediately; pulses are not completed.

## Configuration
- CNN_CSR_IRQ_EN defined: IRQ_EN register and irq_o logic present, as above.
- Not defined: irq_o is tied 0, IRQ_EN reads 0 and ignores writes; all other behaviour is unchanged.

## Test plan
- Reset, then read addresses 0..(4+CH-1) -> every rd_data = 0; start_o = 0, busy_o = 0, irq_o = 0.
- Write SETTING[2] = 0xA5A5_0003, then read it -> rd_data = 0xA5A5_0003 one cycle later; setting_o channel 2 matches.
- Write CTRL = 0x5 -> start_o = 0x5 for exactly one cycle, busy_o = 0x5. Pulse engine_done_i = 0x1 -> STATUS = 0x0_4_1: done = 0x1, busy = 0x4, err = 0.
- While channel 2 is busy: write CTRL = 0x4 -> err[2] set, no start_o pulse. Write SETTING[2] = 0 -> value unchanged.
- IRQ_EN = 0x1 with done[0] set -> irq_o = 1. W1C STATUS = 0x1 in the same cycle as engine_done_i[0] -> done[0] remains 1. A later W1C with no new done -> irq_o falls one cycle after done clears.
- Assert rst while channel 1 is BUSY -> busy_o = 0 immediately; after release, a late engine_done_i[1] is ignored and done stays 0.
